// File: rtl/spi_shift_ctrl.sv
// SPI mode-0 master sequencer: drives an external N-bit shifter through load then N shifts,
// generating SCLK/CS_n and feeding sampled MISO into the shifter's serial input.
module spi_shift_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk_p,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_rx_bit,
  output logic o_busy,
  output logic o_sh_en,
  output logic o_sh_wrt,
  output logic o_sh_bit,
  output logic o_sclk,
  output logic o_cs_n,
  output logic o_done
);

  localparam int unsigned DivW = $clog2(CLK_DIV + 1);
  localparam int unsigned BitW = $clog2(N + 1);
  localparam logic [DivW-1:0] DivLoad = DivW'(CLK_DIV);
  localparam logic [BitW-1:0] BitLast = BitW'(N);

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StHigh, StLow, StDone} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            rx_sample_q, rx_sample_d;
  logic            phase_first, phase_last;

  // div_cnt counts down from CLK_DIV, so the reload value marks the first cycle of a phase.
  assign phase_first = (div_cnt_q == DivLoad);
  assign phase_last  = (div_cnt_q == DivW'(1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sample_d = rx_sample_q;
    div_cnt_d   = div_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = StLoad;
      end
      StLoad: begin
        state_d   = StSetup;
        bit_cnt_d = '0;
      end
      StSetup: begin
        if (phase_last) state_d = StHigh;
      end
      StHigh: begin
        if (phase_first) rx_sample_d = i_rx_bit;
        if (phase_last) state_d = StLow;
      end
      StLow: begin
        if (phase_first) bit_cnt_d = bit_cnt_q + BitW'(1);
        // Compare the updated count so CLK_DIV=1 (first cycle == last cycle) still ends on time.
        if (phase_last) state_d = (bit_cnt_d == BitLast) ? StDone : StHigh;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (state_d != state_q) begin
      div_cnt_d = DivLoad;
    end else if (state_q == StSetup || state_q == StHigh || state_q == StLow) begin
      div_cnt_d = div_cnt_q - DivW'(1);
    end
  end

  always_ff @(posedge i_clk_p) begin
    if (i_rst) begin
      state_q     <= StIdle;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      rx_sample_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sample_q <= rx_sample_d;
    end
  end

  always_comb begin
    o_busy   = (state_q != StIdle);
    o_sh_en  = 1'b0;
    o_sh_wrt = 1'b0;
    o_sh_bit = 1'b0;
    o_sclk   = 1'b0;
    o_cs_n   = 1'b1;
    o_done   = 1'b0;
    unique case (state_q)
      StLoad: begin
        o_sh_en  = 1'b1;
        o_sh_wrt = 1'b1;
      end
      StSetup: begin
        o_cs_n = 1'b0;
      end
      StHigh: begin
        o_cs_n = 1'b0;
        o_sclk = 1'b1;
      end
      StLow: begin
        o_cs_n = 1'b0;
        if (phase_first) begin
          o_sh_en  = 1'b1;
          o_sh_bit = rx_sample_q;
        end
      end
      StDone: begin
        o_done = 1'b1;
      end
      default: begin
        o_busy = (state_q != StIdle);
      end
    endcase
  end

endmodule
